prime_candidate_writer: RTL and testbench
=========================================

PRIME_CANDIDATE_WRITER -- requirements
Module: prime_candidate_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 512, the candidate width in bits.
REQ-002 SHALL have parameter WORD, default 32, the RNG word width; WIDTH/WORD = WORDS (16 at default).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port aclk, input, 1, the rising-edge clock.
REQ-005 SHALL have port areset, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, which permits generation of further candidates.
REQ-007 SHALL have port rng_data, input, WORD, the random word.
REQ-008 SHALL have port rng_valid, input, 1, which qualifies rng_data.
REQ-009 SHALL have port rng_ready, output, 1; a word transfers on any cycle where rng_valid and rng_ready are both high.
REQ-010 SHALL have port fifo_din, output, WIDTH, the candidate written to the prime FIFO.
REQ-011 SHALL have port fifo_wr_en, output, 1, a one-cycle write strobe.
REQ-012 SHALL have port fifo_full, input, 1, the prime FIFO full flag.
REQ-013 SHALL have port cand_count, output, 16, the number of candidates written.
REQ-014 SHALL have port reject_count, output, 16, the number of candidates rejected by the sieve.

Function
REQ-015 SHALL implement states IDLE, COLLECT, CHECK and WRITE.
REQ-016 IDLE SHALL go to COLLECT on the first cycle where enable=1.
REQ-017 COLLECT SHALL drive rng_ready=1; rng_ready SHALL be 0 in every other state.
REQ-018 On each accepted word, COLLECT SHALL place the word at index idx (LSW first, idx 0..WORDS-1) and then increment idx.
REQ-019 Forcing SHALL apply before storage: the word at idx 0 is OR 0x1, so the candidate is odd; the word at idx WORDS-1 is OR 0x80000000, so bit WIDTH-1 is set.
REQ-020 Residues SHALL be computed on the forced word:
- r3 <= (r3 + forced mod 3) mod 3, valid because 2^32 ≡ 1 (mod 3).
- r5 <= (r5 + forced mod 5) mod 5, valid because 2^32 ≡ 1 (mod 5).
- Both residues SHALL clear at the start of each candidate.
REQ-021 Accepting the word at idx WORDS-1 SHALL move the machine to CHECK on the next cycle.
REQ-022 CHECK SHALL last exactly one cycle and branch as follows:
- if r3==0 or r5==0: increment reject_count and discard the candidate;
- otherwise: go to WRITE.
REQ-023 WRITE SHALL assert fifo_wr_en for exactly one cycle, on the first cycle where fifo_full=0, and increment cand_count in that same cycle.
REQ-024 While fifo_full=1, WRITE SHALL hold with fifo_wr_en=0 for an unbounded time.
REQ-025 Minimum latency SHALL be 2 cycles: last word accepted in cycle N, CHECK in N+1, fifo_wr_en high in N+2.
REQ-026 After a CHECK reject or a WRITE strobe, the next state SHALL be COLLECT if enable=1 and IDLE otherwise.
REQ-027 enable SHALL be sampled only in IDLE and at candidate completion; deasserting enable mid-candidate SHALL NOT abort that candidate.
REQ-028 fifo_din SHALL hold the last completed candidate, stable across all non-write cycles, and SHALL never expose a partial candidate.
REQ-029 cand_count and reject_count SHALL saturate at 0xFFFF.
REQ-030 rng_valid gaps SHALL stall COLLECT without loss or duplication of words.

Reset
REQ-031 areset=1 SHALL force: state IDLE, idx=0, r3=r5=0, rng_ready=0, fifo_wr_en=0, fifo_din=0, cand_count=0, reject_count=0.
REQ-032 Reset mid-COLLECT or mid-WRITE SHALL discard the partial or pending candidate, with no write issued.
REQ-033 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-034 Package prime_pkg SHALL hold WIDTH, WORD, WORDS and the state encoding (IDLE=0, COLLECT=1, CHECK=2, WRITE=3), shared with primality_test.
REQ-035 Sub-module small_residue SHALL map one WORD-bit word to its mod-3 and mod-5 values, purely combinationally.
REQ-036 Candidate storage SHALL be one WIDTH-bit register written word-indexed; no internal FIFO.

Verification
REQ-037 All 16 words 0x00000000, fifo_full=0 -> candidate 2^511+1, r3=0 -> rejected; reject_count=1, no fifo_wr_en.
REQ-038 Word0=0x00000002, words 1..15 = 0 -> candidate 2^511+3 (r3=2, r5=1) -> fifo_wr_en exactly 2 cycles after the last word, fifo_din=2^511+3, cand_count=1.
REQ-039 Same as REQ-038 with fifo_full=1 for 10 cycles during WRITE -> fifo_wr_en=0 and rng_ready=0 throughout; a single strobe in the cycle after fifo_full falls.
REQ-040 rng_valid toggled 1-0-1-0 for 32 cycles -> exactly 16 words accepted; candidate word order matches the input order.
REQ-041 areset pulsed after 7 accepted words, then 16 new words (REQ-038 pattern) -> candidate built only from the new words; counts reflect only post-reset activity.
REQ-042 enable dropped after word 3 of a valid candidate -> that candidate is still written, then the machine stays in IDLE with rng_ready=0.

Source files
------------

// File: rtl/prime_candidate_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prime_pkg
//  Description : Shared sizing, FSM state encoding and counter helper for the
//                prime candidate writer and primality_test blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package prime_pkg;

    // Candidate width, RNG word width and the number of words per candidate
    localparam int WIDTH = 512;
    localparam int WORD  = 32;
    localparam int WORDS = WIDTH / WORD;

    // FSM state encoding, kept numerically stable for primality_test
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] CHECK   = 2'd2;
    localparam logic [1:0] WRITE   = 2'd3;

    // Status counters stick at their maximum instead of wrapping
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prime_candidate_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : prime_candidate_writer_if
//  Description : RNG input handshake and prime-FIFO write port of the
//                candidate writer. master = writer side, slave = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prime_candidate_writer_if #(
    parameter int WIDTH = prime_pkg::WIDTH,
    parameter int WORD  = prime_pkg::WORD
) ();

    // RNG word stream
    logic [WORD-1:0]  rng_data;
    logic             rng_valid;
    logic             rng_ready;

    // Prime FIFO write port
    logic [WIDTH-1:0] fifo_din;
    logic             fifo_wr_en;
    logic             fifo_full;

    modport master (
        input  rng_data,
        input  rng_valid,
        output rng_ready,
        output fifo_din,
        output fifo_wr_en,
        input  fifo_full
    );

    modport slave (
        output rng_data,
        output rng_valid,
        input  rng_ready,
        input  fifo_din,
        input  fifo_wr_en,
        output fifo_full
    );

endinterface
`default_nettype wire

// File: rtl/prime_candidate_writer_small_residue.sv
`default_nettype none
// ============================================================================
//  Module      : small_residue
//  Description : Combinational mod-3 and mod-5 of one RNG word. Because
//                16 = 1 (mod 3) and 16 = 1 (mod 5), the word is congruent to
//                the plain sum of its nibbles for both moduli, so only a
//                small-operand reduction remains.
//  Revision    : 1.0 - initial release
// ============================================================================
module small_residue #(
    parameter int WORD = prime_pkg::WORD
) (
    input  logic [WORD-1:0] i_word,
    output logic [1:0]      o_mod3,
    output logic [2:0]      o_mod5
);

    localparam int c_NIBBLES = WORD / 4;
    localparam int c_SUM_W   = $clog2(15 * c_NIBBLES + 1);

    logic [c_SUM_W-1:0] w_sum;

    // Sum of all nibbles; shares both residues with the original word
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < c_NIBBLES; i++) begin
            w_sum = w_sum + c_SUM_W'(i_word[i*4 +: 4]);
        end
    end

    assign o_mod3 = 2'(w_sum % c_SUM_W'(3));
    assign o_mod5 = 3'(w_sum % c_SUM_W'(5));

endmodule
`default_nettype wire

// File: rtl/prime_candidate_writer.sv
`default_nettype none
// ============================================================================
//  Module      : prime_candidate_writer
//  Description : Assembles WIDTH-bit odd, top-bit-set candidates from a
//                stream of RNG words, drops those divisible by 3 or 5 and
//                writes the survivors into the prime FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module prime_candidate_writer #(
    parameter int WIDTH = prime_pkg::WIDTH,
    parameter int WORD  = prime_pkg::WORD
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     enable,
    prime_candidate_writer_if.master bus,
    output logic [15:0]              cand_count,
    output logic [15:0]              reject_count
);

    import prime_pkg::IDLE;
    import prime_pkg::COLLECT;
    import prime_pkg::CHECK;
    import prime_pkg::WRITE;
    import prime_pkg::sat_inc16;

    localparam int                  c_WORDS    = WIDTH / WORD;
    localparam int                  c_IDX_W    = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(c_WORDS - 1);
    localparam logic [WORD-1:0]     c_LSB_SET  = WORD'(1);
    localparam logic [WORD-1:0]     c_MSB_SET  = {1'b1, {(WORD-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [1:0]         r_r3;
    logic [2:0]         r_r5;
    logic [WIDTH-1:0]   r_cand;       // candidate under assembly
    logic [WIDTH-1:0]   r_din;        // last completed, accepted candidate
    logic [15:0]        r_cand_cnt;
    logic [15:0]        r_rej_cnt;

    logic               w_rng_ready;
    logic               w_accept;
    logic               w_last_word;
    logic [WORD-1:0]    w_forced;
    logic [1:0]         w_mod3;
    logic [2:0]         w_mod5;
    logic [2:0]         w_r3_sum;
    logic [3:0]         w_r5_sum;
    logic [1:0]         w_r3_next;
    logic [2:0]         w_r5_next;
    logic               w_reject;
    logic               w_write;
    logic               w_done;
    logic               w_start;

    // ------------------------------------------------------------------
    // Handshake and control decode
    // ------------------------------------------------------------------
    // Reset masks the handshake and the strobe so nothing transfers in a
    // cycle that is about to be wiped.
    assign w_rng_ready = (r_state == COLLECT) & ~areset;
    assign w_accept    = w_rng_ready & bus.rng_valid;
    assign w_last_word = (r_idx == c_LAST_IDX);
    assign w_reject    = (r_state == CHECK) & ((r_r3 == 2'd0) | (r_r5 == 3'd0));
    assign w_write     = (r_state == WRITE) & ~bus.fifo_full & ~areset;
    assign w_done      = w_reject | w_write;
    assign w_start     = enable & ((r_state == IDLE) | w_done);

    // Force the candidate odd (word 0) and full-width (top word)
    always_comb begin
        w_forced = bus.rng_data;
        if (r_idx == '0) begin
            w_forced = w_forced | c_LSB_SET;
        end
        if (w_last_word) begin
            w_forced = w_forced | c_MSB_SET;
        end
    end

    small_residue #(
        .WORD   (WORD)
    ) u_small_residue (
        .i_word (w_forced),
        .o_mod3 (w_mod3),
        .o_mod5 (w_mod5)
    );

    // Running residues: 2^WORD = 1 mod 3 and mod 5, so the residue of the
    // whole candidate is the residue of the sum of its words.
    assign w_r3_sum  = {1'b0, r_r3} + {1'b0, w_mod3};
    assign w_r5_sum  = {1'b0, r_r5} + {1'b0, w_mod5};
    assign w_r3_next = (w_r3_sum >= 3'd3) ? 2'(w_r3_sum - 3'd3) : w_r3_sum[1:0];
    assign w_r5_next = (w_r5_sum >= 4'd5) ? 3'(w_r5_sum - 4'd5) : w_r5_sum[2:0];

    // ------------------------------------------------------------------
    // FSM: IDLE -> COLLECT -> CHECK -> (WRITE) -> COLLECT/IDLE
    // ------------------------------------------------------------------
    // Next-state register; enable only matters in IDLE and on completion
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_accept && w_last_word) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_reject) begin
                        r_state <= enable ? COLLECT : IDLE;
                    end else begin
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_write) begin
                        r_state <= enable ? COLLECT : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Word index and residues: cleared when a new candidate starts,
    // advanced on each accepted word
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_idx <= '0;
            r_r3  <= 2'd0;
            r_r5  <= 3'd0;
        end else if (w_start) begin
            r_idx <= '0;
            r_r3  <= 2'd0;
            r_r5  <= 3'd0;
        end else if (w_accept) begin
            r_r3  <= w_r3_next;
            r_r5  <= w_r5_next;
            r_idx <= w_last_word ? '0 : r_idx + 1'b1;
        end
    end

    // Candidate assembly register, written one word slot at a time
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cand <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < c_WORDS; i++) begin
                if (r_idx == c_IDX_W'(i)) begin
                    r_cand[i*WORD +: WORD] <= w_forced;
                end
            end
        end
    end

    // Output holding register: only a complete candidate that survived the
    // sieve is copied here, so fifo_din never shows a partial value
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_din <= '0;
        end else if ((r_state == CHECK) && !w_reject) begin
            r_din <= r_cand;
        end
    end

    // Saturating written / rejected counters
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cand_cnt <= 16'd0;
            r_rej_cnt  <= 16'd0;
        end else begin
            if (w_reject) begin
                r_rej_cnt <= sat_inc16(r_rej_cnt);
            end
            if (w_write) begin
                r_cand_cnt <= sat_inc16(r_cand_cnt);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rng_ready  = w_rng_ready;
    assign bus.fifo_wr_en = w_write;
    assign bus.fifo_din   = r_din;
    assign cand_count     = r_cand_cnt;
    assign reject_count   = r_rej_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prime_candidate_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prime_candidate_writer
//  Description : Self-checking bench for prime_candidate_writer. A negedge
//                monitor rebuilds every candidate from observed handshakes
//                and sieves it with full-width arithmetic; directed cases
//                cover latency, back-pressure, valid gaps, reset and enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_candidate_writer;

    localparam int WIDTH = 512;
    localparam int WORD  = 32;
    localparam int WORDS = WIDTH / WORD;

    typedef logic [WORD-1:0] words_t [WORDS];

    logic        aclk    = 1'b0;
    logic        areset  = 1'b1;
    logic        enable  = 1'b0;
    logic [15:0] cand_count;
    logic [15:0] reject_count;

    prime_candidate_writer_if #(.WIDTH(WIDTH), .WORD(WORD)) bus ();

    prime_candidate_writer #(
        .WIDTH        (WIDTH),
        .WORD         (WORD)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .enable       (enable),
        .bus          (bus),
        .cand_count   (cand_count),
        .reject_count (reject_count)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] build_cand(input words_t w);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WORDS; i++) begin
            c = c | (WIDTH'(w[i]) << (WORD * i));
        end
        c[0]       = 1'b1;
        c[WIDTH-1] = 1'b1;
        return c;
    endfunction

    function automatic bit is_rejected(input logic [WIDTH-1:0] c);
        return ((c % WIDTH'(3)) == '0) || ((c % WIDTH'(5)) == '0);
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    int               cyc          = 0;
    int               acc_total    = 0;
    int               wr_total     = 0;
    int               last_acc_cyc = 0;
    int               last_wr_cyc  = 0;
    logic [WIDTH-1:0] last_wr_din  = '0;
    logic [WORD-1:0]  words_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [15:0]      m_cand       = 16'd0;
    logic [15:0]      m_rej        = 16'd0;
    bit               rej_pend     = 1'b0;

    // Monitor / scoreboard on the falling edge
    always @(negedge aclk) begin
        words_t           w;
        logic [WIDTH-1:0] c;
        cyc++;
        chk("cand_count", cand_count, m_cand);
        chk("reject_count", reject_count, m_rej);
        if (areset) begin
            chk("rst_rng_ready", bus.rng_ready, 0);
            chk("rst_wr_en", bus.fifo_wr_en, 0);
            words_q.delete();
            exp_q.delete();
            m_cand   = 16'd0;
            m_rej    = 16'd0;
            rej_pend = 1'b0;
        end else begin
            if (rej_pend) begin
                m_rej    = sat16(m_rej);
                rej_pend = 1'b0;
            end
            if (bus.rng_valid && bus.rng_ready) begin
                acc_total++;
                last_acc_cyc = cyc;
                words_q.push_back(bus.rng_data);
                if (words_q.size() == WORDS) begin
                    for (int i = 0; i < WORDS; i++) w[i] = words_q[i];
                    words_q.delete();
                    c = build_cand(w);
                    if (is_rejected(c)) rej_pend = 1'b1;
                    else exp_q.push_back(c);
                end
            end
            if (bus.fifo_wr_en) begin
                wr_total++;
                last_wr_cyc = cyc;
                last_wr_din = bus.fifo_din;
                chk("wr_while_full", bus.fifo_full, 0);
                chk("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("fifo_din", bus.fifo_din, exp_q.pop_front());
                m_cand = sat16(m_cand);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge aclk);
        #2;
    endtask

    task automatic send_word(input logic [WORD-1:0] w);
        bit seen;
        seen = 1'b0;
        bus.rng_data  = w;
        bus.rng_valid = 1'b1;
        for (int t = 0; t < 64 && !seen; t++) begin
            @(negedge aclk);
            if (bus.rng_ready) seen = 1'b1;
            tick();
        end
        bus.rng_valid = 1'b0;
        if (!seen) chk("hs_timeout", seen, 1);
    endtask

    task automatic send_cand(input words_t w);
        for (int i = 0; i < WORDS; i++) send_word(w[i]);
    endtask

    task automatic wait_wr(input int base, input int limit);
        for (int t = 0; t < limit && wr_total == base; t++) at_sample();
        chk("wr_timeout", wr_total > base, 1);
    endtask

    task automatic make_passing(output words_t w);
        for (int i = 0; i < WORDS; i++) w[i] = $urandom;
        while (is_rejected(build_cand(w))) w[0] = w[0] + 32'd2;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        words_t           zeros;
        words_t           pat38;
        words_t           w;
        logic [WIDTH-1:0] exp38;
        int               base;
        int               base_acc;
        int               idx;

        bus.rng_data  = '0;
        bus.rng_valid = 1'b0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            zeros[i] = '0;
            pat38[i] = '0;
        end
        pat38[0]        = 32'h0000_0002;
        exp38           = '0;
        exp38[WIDTH-1]  = 1'b1;
        exp38[1:0]      = 2'b11;

        // Reset state
        tick(); tick(); tick();
        areset = 1'b0;
        at_sample();
        chk("reset_rng_ready", bus.rng_ready, 0);
        chk("reset_wr_en", bus.fifo_wr_en, 0);
        chk("reset_fifo_din", bus.fifo_din, 0);
        chk("reset_cand_count", cand_count, 0);
        chk("reset_reject_count", reject_count, 0);

        // All-zero words: 2^511+1 is divisible by 3
        tick();
        enable = 1'b1;
        tick();
        send_cand(zeros);
        tick(); tick();
        at_sample();
        chk("zero_reject_count", reject_count, 1);
        chk("zero_no_write", wr_total, 0);
        chk("zero_cand_count", cand_count, 0);

        // 2^511+3 passes, strobe two cycles after the last word
        tick();
        base = wr_total;
        send_cand(pat38);
        wait_wr(base, 10);
        chk("lat38_cycles", last_wr_cyc - last_acc_cyc, 2);
        chk("lat38_din", last_wr_din, exp38);
        tick();
        at_sample();
        chk("lat38_cand_count", cand_count, 1);

        // Back-pressure: fifo_full held for 10 cycles in WRITE
        tick();
        bus.fifo_full = 1'b1;
        base = wr_total;
        send_cand(pat38);
        tick();
        for (int i = 0; i < 10; i++) begin
            at_sample();
            chk("full_wr_en", bus.fifo_wr_en, 0);
            chk("full_rng_ready", bus.rng_ready, 0);
            tick();
        end
        enable        = 1'b0;
        bus.fifo_full = 1'b0;
        at_sample();
        chk("full_release_strobe", wr_total - base, 1);
        chk("full_release_din", bus.fifo_din, exp38);
        tick();
        at_sample();
        chk("full_single_strobe", wr_total - base, 1);
        chk("full_idle_ready", bus.rng_ready, 0);
        chk("full_cand_count", cand_count, 2);

        // rng_valid toggling 1-0-1-0 over 32 cycles
        enable = 1'b1;
        tick();
        make_passing(w);
        base     = wr_total;
        base_acc = acc_total;
        idx      = 0;
        for (int c = 0; c < 32; c++) begin
            bus.rng_valid = (c % 2 == 0);
            bus.rng_data  = (idx < WORDS) ? w[idx] : '0;
            @(negedge aclk);
            if (bus.rng_valid && bus.rng_ready) idx++;
            tick();
        end
        bus.rng_valid = 1'b0;
        enable        = 1'b0;
        chk("toggle_accepted", acc_total - base_acc, 16);
        wait_wr(base, 10);
        chk("toggle_din_order", last_wr_din, build_cand(w));

        // Reset after 7 accepted words, then a fresh candidate
        tick();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) send_word($urandom);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        at_sample();
        chk("midrst_din", bus.fifo_din, 0);
        chk("midrst_cand_count", cand_count, 0);
        tick();
        base = wr_total;
        send_cand(pat38);
        wait_wr(base, 10);
        chk("midrst_new_din", last_wr_din, exp38);
        tick();
        at_sample();
        chk("midrst_post_cand", cand_count, 1);
        chk("midrst_post_rej", reject_count, 0);

        // enable dropped after word 3: candidate still completes
        tick();
        make_passing(w);
        base = wr_total;
        for (int i = 0; i < 4; i++) send_word(w[i]);
        enable = 1'b0;
        for (int i = 4; i < WORDS; i++) send_word(w[i]);
        wait_wr(base, 10);
        chk("endrop_din", last_wr_din, build_cand(w));
        base_acc = acc_total;
        bus.rng_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            at_sample();
            chk("endrop_idle_ready", bus.rng_ready, 0);
        end
        bus.rng_valid = 1'b0;
        chk("endrop_no_accept", acc_total - base_acc, 0);

        // Randomized traffic against the scoreboard
        tick();
        enable = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bus.rng_valid = ($urandom_range(0, 3) != 0);
            bus.rng_data  = $urandom;
            bus.fifo_full = ($urandom_range(0, 3) == 0);
            enable        = ($urandom_range(0, 15) != 0);
            tick();
        end
        bus.rng_valid = 1'b0;
        bus.fifo_full = 1'b0;
        enable        = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        at_sample();
        chk("drain_pending_writes", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop in case a bounded wait is somehow bypassed
    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
